piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning parallel word width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning bit order: 1 sends din[0] first, 0 sends din[WIDTH-1] first.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port din, input, WIDTH bits, meaning the parallel word to serialize.
REQ-006 The block SHALL have port load_valid, input, 1 bit, meaning din holds a word offered for transfer.
REQ-007 The block SHALL have port load_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-008 The block SHALL have port serial_out, output, 1 bit, meaning the registered serial bit stream for the downstream shift register's serial input.
REQ-009 The block SHALL have port busy, output, 1 bit, meaning serial_out currently carries a valid data bit.
REQ-010 The block SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse coinciding with the last bit of a frame.

Function
REQ-011 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; there is no other transfer condition.
REQ-012 load_ready SHALL equal NOT pend_valid AND NOT rst, driven from registered state only, with no combinational path from load_valid.
REQ-013 Storage SHALL consist of a WIDTH-bit shifter, a bit counter of clog2(WIDTH) bits, and a one-entry pending register with a pend_valid flag.
REQ-014 FSM states SHALL be IDLE (busy=0) and SHIFT (busy=1).
REQ-015 In IDLE, an accepted word SHALL load directly into the shifter, with the FSM moving to SHIFT, counter=0, and serial_out presenting the first bit after that same edge.
REQ-016 In SHIFT, each rising edge SHALL advance one bit, so each bit is held exactly one clock period; a frame lasts WIDTH cycles.
REQ-017 In SHIFT with counter < WIDTH-1, an accepted word SHALL go to the pending register and set pend_valid.
REQ-018 On the last-bit cycle (counter = WIDTH-1) with pend_valid=1, the pending word SHALL load into the shifter, pend_valid SHALL clear, the FSM SHALL stay in SHIFT, and there SHALL be no gap cycle.
REQ-019 On the last-bit cycle with pend_valid=0 and an accepted word, the word SHALL load directly into the shifter, with no gap cycle.
REQ-020 On the last-bit cycle with nothing pending or accepted, the FSM SHALL go to IDLE and serial_out SHALL return to 0.
REQ-021 frame_done SHALL be 1 exactly in the cycle the last bit of each frame is on serial_out, once per frame, including back-to-back frames.
REQ-022 In IDLE, serial_out SHALL be 0 and frame_done SHALL be 0.
REQ-023 din SHALL be captured only at acceptance; later changes to din SHALL NOT affect a frame in progress or a pending word.
REQ-024 With LSB_FIRST=1, a downstream WIDTH-bit right-shift register clocked on the same clk SHALL hold exactly din after the WIDTH bits of a frame have shifted in.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL set FSM=IDLE, counter=0, shifter=0, pend_valid=0, serial_out=0, busy=0 and frame_done=0.
REQ-026 load_ready SHALL be 0 during every cycle rst is 1, and no word SHALL be accepted on an edge where rst=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame, discard any pending word, and produce no frame_done pulse.
REQ-028 After rst deasserts, load_ready SHALL be 1 in the first cycle.

Verification (WIDTH=4 unless stated)
REQ-029 The bench SHALL hold rst=1 for 2 cycles with load_valid=1 and din=4'hF, and check that serial_out=0, busy=0 and load_ready=0 throughout and that no frame follows.
REQ-030 The bench SHALL accept din=4'b1101 once with LSB_FIRST=1, and check serial_out=1,0,1,1 on 4 consecutive cycles, busy=1 for exactly those 4 cycles, frame_done on the 4th only, and downstream q=4'b1101.
REQ-031 The bench SHALL accept 4'hA and then 4'h5 with load_valid held, and check 8 contiguous bits 0,1,0,1,1,0,1,0, two frame_done pulses 4 cycles apart, and load_ready=0 while 4'h5 is pending.
REQ-032 The bench SHALL offer 3 words back-to-back, and check that the 3rd stalls with load_ready=0 until the last bit of frame 1, then is accepted, giving 12 gapless bits.
REQ-033 The bench SHALL assert rst after 2 bits of frame 4'hC with 4'h3 pending, and check that outputs go to 0 and that the next accepted word 4'h6 yields 0,1,1,0 with no residue.
REQ-034 The bench SHALL set LSB_FIRST=0 and accept din=4'b1000, and check serial_out=1,0,0,0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-entry pending buffer.
// A word loaded while idle drives its first bit on the very next cycle.
// A word offered during a frame is parked in the pending register. It then
// starts on the cycle after the current last bit, so frames run with no gap.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;      // bits still to be sent after serial_q
    logic [WIDTH-1:0] pend_q;
    logic             pend_valid_q;
    logic             serial_q;
    logic             busy_q;
    logic             frame_done_q;

    logic             accept_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] load_word_d;

    // Bit that goes on the line first for a freshly loaded word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (LSB_FIRST != 0) begin
            return w[0];
        end else begin
            return w[WIDTH-1];
        end
    endfunction

    // Drop the bit just sent so the next one sits at the output end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (LSB_FIRST != 0) begin
            return {1'b0, w[WIDTH-1:1]};
        end else begin
            return {w[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Handshake from registered state, and selection of the next frame's source word.
    always_comb begin
        load_ready = ~pend_valid_q & ~rst;
        accept_s   = load_valid & load_ready;
        last_bit_s = (cnt_q == LAST_CNT);
        if (pend_valid_q) begin
            load_word_d = pend_q;
        end else begin
            load_word_d = din;
        end
    end

    // FSM, shifter, counter, pending buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            serial_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q      <= ST_SHIFT;
                        shift_q      <= advance(din);
                        serial_q     <= first_bit(din);
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        frame_done_q <= 1'b0;
                    end else begin
                        cnt_q        <= '0;
                        serial_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit_s) begin
                        if (pend_valid_q || accept_s) begin
                            // Chain the next frame directly behind this last bit.
                            shift_q      <= advance(load_word_d);
                            serial_q     <= first_bit(load_word_d);
                            cnt_q        <= '0;
                            busy_q       <= 1'b1;
                            frame_done_q <= 1'b0;
                            pend_valid_q <= 1'b0;
                        end else begin
                            state_q      <= ST_IDLE;
                            shift_q      <= '0;
                            serial_q     <= 1'b0;
                            cnt_q        <= '0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b0;
                        end
                    end else begin
                        serial_q     <= first_bit(shift_q);
                        shift_q      <= advance(shift_q);
                        cnt_q        <= cnt_q + CNT_W'(1);
                        busy_q       <= 1'b1;
                        frame_done_q <= ((cnt_q + CNT_W'(1)) == LAST_CNT);
                        if (accept_s) begin
                            pend_q       <= din;
                            pend_valid_q <= 1'b1;
                        end else begin
                            pend_valid_q <= pend_valid_q;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    cnt_q        <= '0;
                    shift_q      <= '0;
                    pend_valid_q <= 1'b0;
                    serial_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. It runs one LSB-first and one
// MSB-first instance on shared stimulus. A queue-of-frames model predicts
// every output on every cycle. Directed sequences pin the expected bit
// streams with literals.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] din;

    logic rdy_l, ser_l, busy_l, fd_l;
    logic rdy_m, ser_m, busy_m, fd_m;

    int checks = 0;
    int errors = 0;

    // Model state: fq[0] is the frame on the line, fq[1] the waiting word.
    logic [W-1:0] fq[$];
    int           idx = 0;

    // Driver state: words still to be offered, and a random valid gap.
    logic [W-1:0] offer[$];
    logic         hold_off = 1'b0;

    // Downstream right-shift register fed by the LSB-first stream.
    logic [W-1:0] ds_q = '0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(rdy_l), .serial_out(ser_l), .busy(busy_l), .frame_done(fd_l)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(rdy_m), .serial_out(ser_m), .busy(busy_m), .frame_done(fd_m)
    );

    always @(posedge clk) ds_q <= {ser_l, ds_q[W-1:1]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words enter a frame queue; each frame lasts W cycles.
    always @(posedge clk) begin : model_b
        logic acc;
        acc = load_valid && !rst && (fq.size() < 2);
        if (rst) begin
            fq.delete();
            idx = 0;
        end else begin
            if (fq.size() > 0) begin
                idx++;
                if (idx == W) begin
                    void'(fq.pop_front());
                    idx = 0;
                end
            end
            if (acc) fq.push_back(din);
        end
    end

    // Compare both instances against the model once per cycle.
    always @(negedge clk) begin : cmp_b
        logic [W-1:0] w;
        logic e_busy, e_l, e_m, e_fd, e_rdy;
        e_busy = 1'b0; e_l = 1'b0; e_m = 1'b0; e_fd = 1'b0;
        if (fq.size() > 0) begin
            w      = fq[0];
            e_busy = 1'b1;
            e_l    = w[idx];
            e_m    = w[W-1-idx];
            e_fd   = (idx == W-1);
        end
        e_rdy = !rst && (fq.size() < 2);
        chk("mdl_ser_lsb", ser_l, e_l);
        chk("mdl_busy_lsb", busy_l, e_busy);
        chk("mdl_fd_lsb", fd_l, e_fd);
        chk("mdl_rdy_lsb", rdy_l, e_rdy);
        chk("mdl_ser_msb", ser_m, e_m);
        chk("mdl_busy_msb", busy_m, e_busy);
        chk("mdl_fd_msb", fd_m, e_fd);
        chk("mdl_rdy_msb", rdy_m, e_rdy);
    end

    // One clock: offer the head word (din random otherwise), pop it if taken.
    task automatic cyc();
        logic r;
        if (offer.size() > 0 && !hold_off) begin
            load_valid = 1'b1;
            din        = offer[0];
        end else begin
            load_valid = 1'b0;
            din        = W'($urandom);
        end
        #1;
        r = rdy_l;
        @(posedge clk);
        if (load_valid && r) void'(offer.pop_front());
        @(negedge clk);
        #1;
    endtask

    // Check n cycles against literal masks written in transmit order.
    task automatic expect_stream(input string nm, input bit msb, input int n,
                                 input logic [15:0] bits, input logic [15:0] fds,
                                 input logic [15:0] rdys);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_ser"},  msb ? ser_m  : ser_l,  bits[n-1-i]);
            chk({nm, "_busy"}, msb ? busy_m : busy_l, 1'b1);
            chk({nm, "_fd"},   msb ? fd_m   : fd_l,   fds[n-1-i]);
            chk({nm, "_rdy"},  msb ? rdy_m  : rdy_l,  rdys[n-1-i]);
            cyc();
        end
    endtask

    task automatic expect_idle(input string nm);
        chk({nm, "_idle_busy"}, busy_l, 1'b0);
        chk({nm, "_idle_ser"}, ser_l, 1'b0);
        chk({nm, "_idle_fd"}, fd_l, 1'b0);
    endtask

    initial begin
        // Reset held for two edges with a word offered.
        rst = 1'b1; load_valid = 1'b1; din = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk); #1;
            chk("rst_ser", ser_l, 1'b0);
            chk("rst_busy", busy_l, 1'b0);
            chk("rst_rdy", rdy_l, 1'b0);
        end
        rst = 1'b0; load_valid = 1'b0;
        #1;
        chk("rdy_after_rst", rdy_l, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no_frame_after_rst", busy_l, 1'b0);
        end

        // Single LSB-first frame and downstream capture.
        offer.push_back(4'b1101);
        cyc();
        expect_stream("lsb_1101", 1'b0, 4, 16'b1011, 16'b0001, 16'b1111);
        expect_idle("lsb_1101");
        chk("ds_q_1101", ds_q, 4'b1101);

        // Two chained frames.
        offer.push_back(4'hA); offer.push_back(4'h5);
        cyc();
        expect_stream("a_then_5", 1'b0, 8, 16'b01011010, 16'b00010001, 16'b10001111);
        expect_idle("a_then_5");

        // Three words back to back; the third stalls.
        offer.push_back(4'h9); offer.push_back(4'h6); offer.push_back(4'h3);
        cyc();
        expect_stream("three", 1'b0, 12, 16'b100101101100, 16'b000100010001,
                      16'b100010001111);
        expect_idle("three");

        // Reset mid-frame with a pending word.
        offer.push_back(4'hC); offer.push_back(4'h3);
        cyc();
        chk("c_bit0", ser_l, 1'b0);
        cyc();
        chk("c_bit1", ser_l, 1'b0);
        chk("c_pending_rdy", rdy_l, 1'b0);
        rst = 1'b1;
        cyc();
        expect_idle("midrst");
        chk("midrst_rdy", rdy_l, 1'b0);
        rst = 1'b0;
        cyc();
        expect_idle("post_rst");
        offer.push_back(4'h6);
        cyc();
        expect_stream("after_rst_6", 1'b0, 4, 16'b0110, 16'b0001, 16'b1111);
        expect_idle("after_rst_6");

        // MSB-first instance.
        offer.push_back(4'b1000);
        cyc();
        expect_stream("msb_1000", 1'b1, 4, 16'b1000, 16'b0001, 16'b1111);
        chk("msb_idle", busy_m, 1'b0);

        // Random traffic, valid gaps and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (offer.size() < 3 && $urandom_range(0, 2) != 0)
                offer.push_back(W'($urandom));
            hold_off = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; hold_off = 1'b0; offer.delete();
        for (int i = 0; i < 12; i++) cyc();
        expect_idle("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
